// File: rtl/hlx_axi_lite_reg_slave.sv
// ============================================================================
// hlx_axi_lite_reg_slave : AXI4-Lite responder for a RW control / RO status bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module hlx_axi_lite_reg_slave #(
   parameter int AXI_LITE_AW = 32,
   parameter int AXI_LITE_DW = 32,
   parameter int NUM_RW      = 8,
   parameter int NUM_RO      = 8
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic [AXI_LITE_AW-1:0]                AXI_LITE_awaddr,
   input  logic [2:0]                            AXI_LITE_awprot,
   input  logic                                  AXI_LITE_awvalid,
   output logic                                  AXI_LITE_awready,
   input  logic [AXI_LITE_DW-1:0]                AXI_LITE_wdata,
   input  logic [AXI_LITE_DW/8-1:0]              AXI_LITE_wstrb,
   input  logic                                  AXI_LITE_wvalid,
   output logic                                  AXI_LITE_wready,
   output logic [1:0]                            AXI_LITE_bresp,
   output logic                                  AXI_LITE_bvalid,
   input  logic                                  AXI_LITE_bready,
   input  logic [AXI_LITE_AW-1:0]                AXI_LITE_araddr,
   input  logic [2:0]                            AXI_LITE_arprot,
   input  logic                                  AXI_LITE_arvalid,
   output logic                                  AXI_LITE_arready,
   output logic [AXI_LITE_DW-1:0]                AXI_LITE_rdata,
   output logic [1:0]                            AXI_LITE_rresp,
   output logic                                  AXI_LITE_rvalid,
   input  logic                                  AXI_LITE_rready,
   output logic [NUM_RW*AXI_LITE_DW-1:0]         rw_regs,
   output logic [NUM_RW-1:0]                     rw_wr_pulse,
   input  logic [((NUM_RO > 0) ? NUM_RO : 1)*AXI_LITE_DW-1:0] ro_status
);

   localparam int         IDX_W  = AXI_LITE_AW - 2;
   localparam int         NB     = AXI_LITE_DW / 8;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic                          aw_held_q, aw_held_d;
   logic [IDX_W-1:0]              aw_idx_q, aw_idx_d;
   logic                          w_held_q, w_held_d;
   logic [AXI_LITE_DW-1:0]        wdata_q, wdata_d;
   logic [NB-1:0]                 wstrb_q, wstrb_d;
   logic                          bvalid_q, bvalid_d;
   logic [1:0]                    bresp_q, bresp_d;
   logic                          rvalid_q, rvalid_d;
   logic [AXI_LITE_DW-1:0]        rdata_q, rdata_d;
   logic [1:0]                    rresp_q, rresp_d;
   logic [NUM_RW*AXI_LITE_DW-1:0] regs_q, regs_d;
   logic [NUM_RW-1:0]             pulse_q, pulse_d;

   logic                   aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]       wr_idx, rd_idx;
   logic [AXI_LITE_DW-1:0] wr_data, rd_word;
   logic [NB-1:0]          wr_strb;
   logic                   wr_is_rw, rd_is_rw, rd_is_ro;
   logic                   unused_bits;

   assign unused_bits = ^{AXI_LITE_awprot, AXI_LITE_arprot,
                          AXI_LITE_awaddr[1:0], AXI_LITE_araddr[1:0]};

   assign AXI_LITE_awready = aresetn & ~aw_held_q & ~bvalid_q;
   assign AXI_LITE_wready  = aresetn & ~w_held_q & ~bvalid_q;
   assign AXI_LITE_arready = aresetn & ~rvalid_q;
   assign AXI_LITE_bvalid  = bvalid_q;
   assign AXI_LITE_bresp   = bresp_q;
   assign AXI_LITE_rvalid  = rvalid_q;
   assign AXI_LITE_rdata   = rdata_q;
   assign AXI_LITE_rresp   = rresp_q;
   assign rw_regs          = regs_q;
   assign rw_wr_pulse      = pulse_q;

   assign aw_hs = AXI_LITE_awvalid & AXI_LITE_awready;
   assign w_hs  = AXI_LITE_wvalid & AXI_LITE_wready;
   assign ar_hs = AXI_LITE_arvalid & AXI_LITE_arready;

   // A handshake in this cycle counts as held, so same-cycle AW+W commits now.
   assign wr_idx  = aw_held_q ? aw_idx_q : AXI_LITE_awaddr[AXI_LITE_AW-1:2];
   assign wr_data = w_held_q ? wdata_q : AXI_LITE_wdata;
   assign wr_strb = w_held_q ? wstrb_q : AXI_LITE_wstrb;
   assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);

   assign wr_is_rw = wr_idx < IDX_W'(NUM_RW);
   assign rd_idx   = AXI_LITE_araddr[AXI_LITE_AW-1:2];
   assign rd_is_rw = rd_idx < IDX_W'(NUM_RW);
   assign rd_is_ro = ~rd_is_rw & (rd_idx < IDX_W'(NUM_RW + NUM_RO));

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (rd_idx == IDX_W'(i)) rd_word = regs_q[AXI_LITE_DW*i +: AXI_LITE_DW];
      end
      for (int j = 0; j < NUM_RO; j++) begin
         if (rd_idx == IDX_W'(NUM_RW + j)) rd_word = ro_status[AXI_LITE_DW*j +: AXI_LITE_DW];
      end
   end

   always_comb begin
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      regs_d    = regs_q;
      pulse_d   = '0;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = AXI_LITE_awaddr[AXI_LITE_AW-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = AXI_LITE_wdata;
         wstrb_d  = AXI_LITE_wstrb;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_is_rw ? OKAY : SLVERR;
         for (int i = 0; i < NUM_RW; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               pulse_d[i] = 1'b1;
               for (int k = 0; k < NB; k++) begin
                  if (wr_strb[k]) regs_d[AXI_LITE_DW*i + 8*k +: 8] = wr_data[8*k +: 8];
               end
            end
         end
      end else if (bvalid_q & AXI_LITE_bready) begin
         bvalid_d = 1'b0;
      end

      // Read samples pre-commit register state, so a colliding write is not seen.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
         rresp_d  = (rd_is_rw | rd_is_ro) ? OKAY : SLVERR;
      end else if (rvalid_q & AXI_LITE_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         regs_q    <= '0;
         pulse_q   <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
         pulse_q   <= pulse_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hlx_axi_lite_reg_slave.sv
// ============================================================================
// tb_hlx_axi_lite_reg_slave : vector table, corner sequences and random traffic
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hlx_axi_lite_reg_slave;

   localparam int NRW = 8;
   localparam int NRO = 8;

   logic               aclk = 1'b0;
   logic               aresetn;
   logic [31:0]        awaddr, wdata, araddr;
   logic [2:0]         awprot, arprot;
   logic [3:0]         wstrb;
   logic               awvalid, wvalid, bready, arvalid, rready;
   logic               awready, wready, bvalid, arready, rvalid;
   logic [1:0]         bresp, rresp;
   logic [31:0]        rdata;
   logic [NRW*32-1:0]  rw_regs;
   logic [NRW-1:0]     rw_wr_pulse;
   logic [NRO*32-1:0]  ro_status;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_rw [NRW];
   logic [31:0] ro_w [NRO];

   hlx_axi_lite_reg_slave #(.AXI_LITE_AW(32), .AXI_LITE_DW(32), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .AXI_LITE_awaddr(awaddr), .AXI_LITE_awprot(awprot), .AXI_LITE_awvalid(awvalid),
      .AXI_LITE_awready(awready),
      .AXI_LITE_wdata(wdata), .AXI_LITE_wstrb(wstrb), .AXI_LITE_wvalid(wvalid),
      .AXI_LITE_wready(wready),
      .AXI_LITE_bresp(bresp), .AXI_LITE_bvalid(bvalid), .AXI_LITE_bready(bready),
      .AXI_LITE_araddr(araddr), .AXI_LITE_arprot(arprot), .AXI_LITE_arvalid(arvalid),
      .AXI_LITE_arready(arready),
      .AXI_LITE_rdata(rdata), .AXI_LITE_rresp(rresp), .AXI_LITE_rvalid(rvalid),
      .AXI_LITE_rready(rready),
      .rw_regs(rw_regs), .rw_wr_pulse(rw_wr_pulse), .ro_status(ro_status)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_ro(input int j, input logic [31:0] v);
      ro_w[j] = v;
      ro_status[32*j +: 32] = v;
   endtask

   // Reference: word index = addr/4; RW first, then RO, everything else errors.
   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp,
                              output logic [NRW-1:0] pulse);
      int idx;
      idx   = int'(addr >> 2);
      pulse = '0;
      if (idx < NRW) begin
         for (int k = 0; k < 4; k++)
            if (strb[k]) m_rw[idx][8*k +: 8] = data[8*k +: 8];
         pulse[idx] = 1'b1;
         resp = 2'b00;
      end else begin
         resp = 2'b10;
      end
   endtask

   task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic [1:0] resp);
      int idx;
      idx = int'(addr >> 2);
      if (idx < NRW) begin
         data = m_rw[idx]; resp = 2'b00;
      end else if (idx < NRW + NRO) begin
         data = ro_w[idx - NRW]; resp = 2'b00;
      end else begin
         data = 32'h0; resp = 2'b10;
      end
   endtask

   task automatic check_regs(input string name);
      for (int i = 0; i < NRW; i++) check(name, rw_regs[32*i +: 32], m_rw[i]);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp);
      int cyc;
      bit aw_done, w_done;
      logic [1:0] exp_resp;
      logic [NRW-1:0] exp_pulse;
      aw_done = 0; w_done = 0; cyc = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && cyc < 50) begin
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         tick();
         cyc++;
         if (!(aw_done && w_done)) check("wr_no_early_b", bvalid, 1'b0);
      end
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
      model_write(addr, data, strb, exp_resp, exp_pulse);
      check("wr_bvalid", bvalid, 1'b1);
      check("wr_bresp", bresp, exp_resp);
      check("wr_pulse", rw_wr_pulse, exp_pulse);
      check_regs("wr_regs");
      resp = bresp;
      bready = 1;
      tick();
      bready = 0;
      check("wr_bvalid_clr", bvalid, 1'b0);
      check("wr_pulse_clr", rw_wr_pulse, '0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
      int cyc;
      cyc = 0;
      araddr = addr; arvalid = 1;
      while (!arready && cyc < 50) begin tick(); cyc++; end
      if (!arready) check("rd_arready_timeout", 0, 1);
      tick();
      arvalid = 0;
      check("rd_rvalid", rvalid, 1'b1);
      data = rdata; resp = rresp;
      for (int d = 0; d < r_dly; d++) tick();
      check("rd_rdata_hold", rdata, data);
      rready = 1;
      tick();
      rready = 0;
      check("rd_rvalid_clr", rvalid, 1'b0);
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vt[14];

   initial begin
      logic [31:0] rd, exp_d, old_v;
      logic [1:0]  rs, exp_r;
      logic [NRW-1:0] ep;

      vt[0]  = '{1'b1, 32'h08,  32'hA5A5_1234, 4'hF, 32'h0,         2'b00};
      vt[1]  = '{1'b0, 32'h08,  32'h0,         4'h0, 32'hA5A5_1234, 2'b00};
      vt[2]  = '{1'b1, 32'h04,  32'h1122_3344, 4'hF, 32'h0,         2'b00};
      vt[3]  = '{1'b1, 32'h04,  32'hAABB_CCDD, 4'h6, 32'h0,         2'b00};
      vt[4]  = '{1'b0, 32'h04,  32'h0,         4'h0, 32'h11BB_CC44, 2'b00};
      vt[5]  = '{1'b1, 32'h20,  32'h1234_5678, 4'hF, 32'h0,         2'b10};
      vt[6]  = '{1'b0, 32'h20,  32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
      vt[7]  = '{1'b0, 32'h40,  32'h0,         4'h0, 32'h0,         2'b10};
      vt[8]  = '{1'b1, 32'h1F,  32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
      vt[9]  = '{1'b0, 32'h1C,  32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
      vt[10] = '{1'b1, 32'h0C,  32'h5555_5555, 4'h0, 32'h0,         2'b00};
      vt[11] = '{1'b0, 32'h0C,  32'h0,         4'h0, 32'h0,         2'b00};
      vt[12] = '{1'b0, 32'h3C,  32'h0,         4'h0, 32'h7777_0007, 2'b00};
      vt[13] = '{1'b1, 32'h100, 32'h0BAD_0BAD, 4'hF, 32'h0,         2'b10};

      awprot = 3'b0; arprot = 3'b0;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      ro_status = '0;
      for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
      for (int j = 0; j < NRO; j++) set_ro(j, 32'h0);

      // Reset with requests pending
      aresetn = 0; awvalid = 1; wvalid = 1; arvalid = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("rst_readies", {awready, wready, arready}, 3'b000);
         check("rst_valids", {bvalid, rvalid}, 2'b00);
         check("rst_regs_zero", |rw_regs, 1'b0);
      end
      awvalid = 0; wvalid = 0; arvalid = 0;
      aresetn = 1;
      tick();
      check("post_rst_readies", {awready, wready, arready}, 3'b111);

      // Table vectors
      set_ro(0, 32'hCAFE_F00D);
      set_ro(7, 32'h7777_0007);
      for (int v = 0; v < 14; v++) begin
         if (vt[v].is_wr) begin
            do_write(vt[v].addr, vt[v].data, vt[v].strb, 0, 0, rs);
            check("tbl_bresp", rs, vt[v].exp_resp);
         end else begin
            do_read(vt[v].addr, 0, rd, rs);
            check("tbl_rdata", rd, vt[v].exp_data);
            check("tbl_rresp", rs, vt[v].exp_resp);
         end
      end

      // W three cycles ahead of AW; commit must follow the AW handshake
      do_write(32'h00, 32'hFFFF_FFFF, 4'h5, 3, 0, rs);
      check("w_first_reg0", rw_regs[31:0], 32'h00FF_00FF);

      // Write response backpressure
      awaddr = 32'h10; wdata = 32'h1357_9BDF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      model_write(32'h10, 32'h1357_9BDF, 4'hF, exp_r, ep);
      for (int c = 0; c < 5; c++) begin
         check("bp_b_state", {bvalid, bresp, awready, wready}, {1'b1, exp_r, 2'b00});
         tick();
      end
      bready = 1; tick(); bready = 0;
      check("bp_b_release", {bvalid, awready, wready}, 3'b011);
      check_regs("bp_regs");

      // Read backpressure with changing status
      set_ro(1, 32'h1111_0000);
      araddr = 32'h24; arvalid = 1;
      tick();
      arvalid = 0;
      for (int c = 0; c < 4; c++) begin
         set_ro(1, $urandom);
         tick();
         check("bp_r_hold", {rvalid, rdata, rresp}, {1'b1, 32'h1111_0000, 2'b00});
      end
      rready = 1; tick(); rready = 0;
      check("bp_r_release", rvalid, 1'b0);

      // Same-cycle read and write of one register
      old_v = m_rw[1];
      araddr = 32'h04; arvalid = 1;
      awaddr = 32'h04; wdata = 32'h0BAD_CAFE; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      check("conc_readies", {awready, wready, arready}, 3'b111);
      tick();
      arvalid = 0; awvalid = 0; wvalid = 0;
      model_write(32'h04, 32'h0BAD_CAFE, 4'hF, exp_r, ep);
      check("conc_rdata_old", {rvalid, rdata}, {1'b1, old_v});
      check("conc_bvalid", {bvalid, bresp}, {1'b1, exp_r});
      check("conc_reg_new", rw_regs[63:32], 32'h0BAD_CAFE);
      bready = 1; rready = 1; tick(); bready = 0; rready = 0;

      // Randomised traffic against the reference model
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
         set_ro($urandom_range(0, NRO - 1), $urandom);
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rs);
         end else begin
            model_read(a, exp_d, exp_r);
            do_read(a, $urandom_range(0, 3), rd, rs);
            check("rnd_rdata", rd, exp_d);
            check("rnd_rresp", rs, exp_r);
         end
      end

      // Reset while a write response is pending
      awaddr = 32'h18; wdata = 32'h2468_ACE0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      check("mid_rst_pre_bvalid", bvalid, 1'b1);
      aresetn = 0;
      tick();
      for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
      check("mid_rst_bvalid", bvalid, 1'b0);
      check("mid_rst_pulse", rw_wr_pulse, '0);
      check_regs("mid_rst_regs");
      aresetn = 1; bready = 1; rready = 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("mid_rst_no_stale", {bvalid, rvalid}, 2'b00);
      end
      bready = 0; rready = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hlx_axi_lite_reg_slave.md
Name: hlx_axi_lite_reg_slave

Overview:
AXI4-Lite responder (slave end of the hlx AXI-Lite interface) implementing a control/status register bank. Host-side masters (PCIe bridge, JTAG-AXI) read and write it. It exports read-write control words plus per-register write strobes to fabric logic such as DDR4 self-refresh sequencing, and returns fabric status words as read-only registers.

Parameters:
AXI_LITE_AW, 32, address width
AXI_LITE_DW, 32, data width; only 32 is supported
NUM_RW, 8, number of read-write registers (1..64)
NUM_RO, 8, number of read-only status registers (0..64)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
AXI_LITE_awaddr  in  AW  write address
AXI_LITE_awprot  in  3  ignored
AXI_LITE_awvalid  in  1  write address valid
AXI_LITE_awready  out  1  write address ready
AXI_LITE_wdata  in  32  write data
AXI_LITE_wstrb  in  4  byte enables
AXI_LITE_wvalid  in  1  write data valid
AXI_LITE_wready  out  1  write data ready
AXI_LITE_bresp  out  2  write response
AXI_LITE_bvalid  out  1  write response valid
AXI_LITE_bready  in  1  write response ready
AXI_LITE_araddr  in  AW  read address
AXI_LITE_arprot  in  3  ignored
AXI_LITE_arvalid  in  1  read address valid
AXI_LITE_arready  out  1  read address ready
AXI_LITE_rdata  out  32  read data
AXI_LITE_rresp  out  2  read response
AXI_LITE_rvalid  out  1  read data valid
AXI_LITE_rready  in  1  read data ready
rw_regs  out  NUM_RW*32  RW register contents; reg i at [32i+31:32i]
rw_wr_pulse  out  NUM_RW  1-cycle pulse, bit i, on each committed write to reg i
ro_status  in  NUM_RO*32  status words; word j at [32j+31:32j]

Behaviour:
- Clock and reset: one clock domain (aclk). Reset is synchronous and active-low on aresetn. While aresetn=0: all RW regs=0, rw_wr_pulse=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, AW/W holding flags cleared. awready, wready and arready are forced to 0.
- Reset mid-transaction: any latched AW/W and any pending B/R response is dropped silently. No response is issued after reset.
- Address decode: idx = addr[AW-1:2]; addr[1:0] ignored.
  - idx < NUM_RW selects RW reg idx.
  - NUM_RW <= idx < NUM_RW+NUM_RO selects RO word idx-NUM_RW.
  - Any other idx is unmapped.
- Write channel, AW/W accepted independently in either order:
  - awready = aresetn & !aw_held & !bvalid; handshake latches awaddr and sets aw_held.
  - wready = aresetn & !w_held & !bvalid; handshake latches wdata/wstrb and sets w_held.
- Write commit happens at the edge where both are held (a handshake in the current cycle counts as held). Same-cycle AW+W handshake in cycle N gives bvalid=1 in cycle N+1.
  - RW target: byte k updated only where wstrb[k]=1. New value is visible on rw_regs in N+1. rw_wr_pulse[idx]=1 for exactly cycle N+1, even when wstrb=0. bresp=OKAY (2'b00).
  - RO or unmapped target: no state change, no pulse, bresp=SLVERR (2'b10).
  - The commit clears aw_held and w_held.
- bvalid holds, with bresp stable, until bready=1. It clears on the edge where bvalid&bready. awready/wready are low while bvalid=1, so at most one write is outstanding.
- Read channel:
  - arready = aresetn & !rvalid. An AR handshake in cycle N gives rvalid=1 in N+1.
  - rdata is the target value sampled in cycle N: RW reg contents, or ro_status word with rresp=OKAY. Unmapped: rdata=0, rresp=SLVERR.
  - rdata/rresp are held stable until rvalid&rready. Max rate is one read per 2 cycles.
- Read/write independence: read and write paths run concurrently. A read sampled in the same cycle as a write commit to the same reg returns the pre-write value.
- ro_status is sampled only at AR handshake. It is not re-sampled while rvalid is stalled.

Test Plan:
- Reset: aresetn=0 for 4 cycles with arvalid=awvalid=1 -> all readies=0, bvalid=rvalid=0, rw_regs=0. The cycle after release, awready=wready=arready=1.
- Full write + readback: AW 0x08, W 0xA5A5_1234 with wstrb=0xF in the same cycle -> bvalid next cycle, bresp=00, rw_wr_pulse[2] for 1 cycle. Read 0x08 -> rdata=0xA5A5_1234, rresp=00.
- Byte strobes and ordering: W (0xFFFF_FFFF, wstrb=0x5) 3 cycles before AW 0x00 -> reg0=0x00FF_00FF. Commit occurs the cycle after the AW handshake.
- Backpressure: bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout. rready=0 on a read -> rdata stable while ro_status changes.
- Errors: write 0x20 (RO word 0) -> SLVERR, rw_regs unchanged. Read 0x40 with NUM_RW=NUM_RO=8 -> rdata=0, rresp=10. Read 0x20 with ro_status[31:0]=0xCAFE_F00D -> 0xCAFE_F00D, OKAY.
- Concurrency and reset mid-operation: read and write to 0x04 in the same cycle -> read returns the old value. Assert aresetn=0 while bvalid=1 -> bvalid drops and no stale response appears after reset.
